// File: rtl/piso_stream_nword.sv
// piso_stream_nword: parallel-in/serial-out word shifter with ready/valid on both sides (optional PISO_PREFETCH_EN adds a one-load holding register)
module piso_stream_nword #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DEPTH*DATA_W-1:0] par_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);
  localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                  state;
  logic [DEPTH*DATA_W-1:0] sreg;
  logic [CW-1:0]           cnt;
  logic                    beat, last_beat, load;
  assign out_data  = sreg[DATA_W-1:0];
  assign out_valid = state == SHIFT;
  assign busy      = state == SHIFT;
  assign out_last  = out_valid && cnt == LAST;
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && out_last;
  assign load      = load_valid && load_ready;
`ifdef PISO_PREFETCH_EN
  logic [DEPTH*DATA_W-1:0] hold;
  logic                    full;
  assign load_ready = !full;
  // shift/emit control; a queued load takes over the shifter on the last beat without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      hold  <= '0;
      full  <= 1'b0;
    end else if (state == IDLE) begin
      if (load) begin
        sreg  <= par_in;
        cnt   <= '0;
        state <= SHIFT;
      end
    end else begin
      if (last_beat) begin
        cnt <= '0;
        if (full) begin
          sreg <= hold;
          full <= 1'b0;
        end else if (load) begin
          sreg <= par_in;
        end else begin
          sreg  <= sreg >> DATA_W;
          state <= IDLE;
        end
      end else begin
        if (beat) begin
          sreg <= sreg >> DATA_W;
          cnt  <= cnt + 1'b1;
        end
        if (load) begin
          hold <= par_in;
          full <= 1'b1;
        end
      end
    end
  end
`else
  assign load_ready = state == IDLE;
  // shift/emit control; loads are only taken while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (load) begin
        sreg  <= par_in;
        cnt   <= '0;
        state <= SHIFT;
      end
    end else if (beat) begin
      sreg  <= sreg >> DATA_W;
      cnt   <= last_beat ? '0 : cnt + 1'b1;
      state <= last_beat ? IDLE : SHIFT;
    end
  end
`endif
endmodule
